// File: rtl/multi_blinker.sv
// multi_blinker: one shared prescaler tick driving CHANNELS LEDs.
// Per-channel OFF/ON/BLINK/ONESHOT, configured via a one-slot valid/ready port.
module multi_blinker #(
  parameter int FREQ     = 25000000,
  parameter int TICK_HZ  = 1000,
  parameter int CHANNELS = 4,
  parameter int PW       = 16,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  input  logic [CW-1:0]       cfg_ch_i,
  input  logic [1:0]          cfg_mode_i,
  input  logic [PW-1:0]       cfg_period_i,
  input  logic [PW-1:0]       cfg_duty_i,
  output logic                tick_o,
  output logic [CHANNELS-1:0] led_o
);

  localparam int DIV = FREQ / TICK_HZ;
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

  if ((FREQ % TICK_HZ) != 0 || DIV < 2) begin : g_bad_div
    $fatal(1, "multi_blinker: FREQ/TICK_HZ must be integral and >= 2");
  end
  if (CHANNELS < 1) begin : g_bad_ch
    $fatal(1, "multi_blinker: CHANNELS must be >= 1");
  end

  typedef enum logic [1:0] {
    M_OFF   = 2'd0,
    M_ON    = 2'd1,
    M_BLINK = 2'd2,
    M_ONE   = 2'd3
  } mode_t;

  logic [DW-1:0]       r_cnt;
  logic                r_tick;

  logic                r_pend;
  logic [CW-1:0]       r_p_ch;
  mode_t               r_p_mode;
  logic [PW-1:0]       r_p_per;
  logic [PW-1:0]       r_p_duty;

  mode_t               r_mode [CHANNELS];
  logic [PW-1:0]       r_per  [CHANNELS];
  logic [PW-1:0]       r_duty [CHANNELS];
  logic [PW-1:0]       r_ph   [CHANNELS];
  logic [CHANNELS-1:0] r_led;

  mode_t               w_mode [CHANNELS];
  logic [PW-1:0]       w_per  [CHANNELS];
  logic [PW-1:0]       w_duty [CHANNELS];
  logic [PW-1:0]       w_ph   [CHANNELS];
  logic [PW-1:0]       w_nph  [CHANNELS];
  logic [CHANNELS-1:0] w_led;
  logic [CHANNELS-1:0] w_sel;
  logic                w_acc;
  logic                w_apply;

  assign w_acc       = cfg_valid_i && !r_pend;
  assign w_apply     = r_tick && r_pend;
  // out-of-range channel codes shift out of the vector and select nothing
  assign w_sel       = w_apply ? (CHANNELS'(1) << r_p_ch) : '0;
  assign cfg_ready_o = !r_pend;
  assign tick_o      = r_tick;
  assign led_o       = r_led;

  // prescaler: wrap at DIV-1 and emit a registered one-cycle tick
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == DW'(DIV - 1)) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + DW'(1);
      r_tick <= 1'b0;
    end
  end

  // single pending config slot, filled on accept, drained on a tick edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pend   <= 1'b0;
      r_p_ch   <= '0;
      r_p_mode <= M_OFF;
      r_p_per  <= '0;
      r_p_duty <= '0;
    end else if (w_acc) begin
      r_pend   <= 1'b1;
      r_p_ch   <= cfg_ch_i;
      r_p_mode <= mode_t'(cfg_mode_i);
      r_p_per  <= cfg_period_i;
      r_p_duty <= cfg_duty_i;
    end else if (w_apply) begin
      r_pend   <= 1'b0;
    end
  end

  // next channel state: load on apply, otherwise advance on tick edges
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      w_mode[i] = r_mode[i];
      w_per[i]  = r_per[i];
      w_duty[i] = r_duty[i];
      w_ph[i]   = r_ph[i];
      w_nph[i]  = '0;
      w_led[i]  = r_led[i];
      if (w_sel[i]) begin
        w_mode[i] = r_p_mode;
        w_per[i]  = (r_p_per == '0) ? PW'(1) : r_p_per;
        w_duty[i] = r_p_duty;
        w_ph[i]   = '0;
        unique case (r_p_mode)
          M_OFF:   w_led[i] = 1'b0;
          M_ON:    w_led[i] = 1'b1;
          M_BLINK: w_led[i] = (r_p_duty != '0);
          M_ONE: begin
            w_led[i] = (r_p_duty != '0);
            if (r_p_duty == '0) w_mode[i] = M_OFF;
          end
        endcase
      end else if (r_tick) begin
        unique case (r_mode[i])
          M_OFF:   w_led[i] = 1'b0;
          M_ON:    w_led[i] = 1'b1;
          M_BLINK: begin
            w_nph[i] = (r_ph[i] == r_per[i] - PW'(1)) ? '0
                     : r_ph[i] + PW'(1);
            w_ph[i]  = w_nph[i];
            w_led[i] = (w_nph[i] < r_duty[i]);
          end
          M_ONE: begin
            w_nph[i] = r_ph[i] + PW'(1);
            w_ph[i]  = w_nph[i];
            if (w_nph[i] >= r_duty[i]) begin
              w_mode[i] = M_OFF;
              w_led[i]  = 1'b0;
            end else begin
              w_led[i]  = 1'b1;
            end
          end
        endcase
      end
    end
  end

  // channel state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_mode[i] <= M_OFF;
        r_per[i]  <= PW'(1);
        r_duty[i] <= '0;
        r_ph[i]   <= '0;
      end
      r_led <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_mode[i] <= w_mode[i];
        r_per[i]  <= w_per[i];
        r_duty[i] <= w_duty[i];
        r_ph[i]   <= w_ph[i];
      end
      r_led <= w_led;
    end
  end

endmodule

// File: tb/tb_multi_blinker.sv
// tb_multi_blinker: random + directed stimulus against a tick-count model.
// A second 3-channel instance sees the same writes; code 3 is out of range there.
module tb_multi_blinker;

  localparam int FREQ = 100;
  localparam int THZ  = 10;
  localparam int DIV  = 10;
  localparam int CH   = 4;
  localparam int PW   = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic [1:0]    cfg_ch = '0;
  logic [1:0]    cfg_mode = '0;
  logic [PW-1:0] cfg_per = '0;
  logic [PW-1:0] cfg_duty = '0;
  logic          ready, tick;
  logic [CH-1:0] led;
  logic          ready2, tick2;
  logic [2:0]    led2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  multi_blinker #(
    .FREQ(FREQ), .TICK_HZ(THZ), .CHANNELS(CH), .PW(PW)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(ready),
    .cfg_ch_i(cfg_ch), .cfg_mode_i(cfg_mode),
    .cfg_period_i(cfg_per), .cfg_duty_i(cfg_duty),
    .tick_o(tick), .led_o(led)
  );

  multi_blinker #(
    .FREQ(FREQ), .TICK_HZ(THZ), .CHANNELS(3), .PW(PW)
  ) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .cfg_valid_i(cfg_valid), .cfg_ready_o(ready2),
    .cfg_ch_i(cfg_ch), .cfg_mode_i(cfg_mode),
    .cfg_period_i(cfg_per), .cfg_duty_i(cfg_duty),
    .tick_o(tick2), .led_o(led2)
  );

  // model: per channel mode/period/duty and ticks elapsed since apply
  int m_edges = 0;
  bit m_tick  = 1'b0;
  bit m_pend  = 1'b0;
  int p_ch, p_mode, p_per, p_duty;
  int mm [CH] = '{default: 0};
  int mp [CH] = '{default: 1};
  int md [CH] = '{default: 0};
  int mn [CH] = '{default: 0};

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit exp_led(input int i);
    case (mm[i])
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (mn[i] % mp[i]) < md[i];
      default: return mn[i] < md[i];
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin : mdl
    bit app, acc;
    if (!rst_n) begin
      m_edges = 0;
      m_tick  = 1'b0;
      m_pend  = 1'b0;
      for (int i = 0; i < CH; i++) begin
        mm[i] = 0; mp[i] = 1; md[i] = 0; mn[i] = 0;
      end
    end else begin
      app = m_tick && m_pend;
      acc = cfg_valid && !m_pend;
      if (m_tick)
        for (int i = 0; i < CH; i++) mn[i]++;
      if (app) begin
        m_pend     = 1'b0;
        mm[p_ch]   = p_mode;
        mp[p_ch]   = (p_per == 0) ? 1 : p_per;
        md[p_ch]   = p_duty;
        mn[p_ch]   = 0;
      end
      if (acc) begin
        m_pend = 1'b1;
        p_ch   = int'(cfg_ch);
        p_mode = int'(cfg_mode);
        p_per  = int'(cfg_per);
        p_duty = int'(cfg_duty);
      end
      m_edges++;
      m_tick = (m_edges % DIV) == 0;
    end
  end

  always @(negedge clk) begin : cmp
    logic [CH-1:0] e;
    for (int i = 0; i < CH; i++) e[i] = exp_led(i);
    chk("tick", int'(tick), int'(m_tick));
    chk("ready", int'(ready), int'(!m_pend));
    chk("led", int'(led), int'(e));
    chk("tick3", int'(tick2), int'(m_tick));
    chk("ready3", int'(ready2), int'(!m_pend));
    chk("led3", int'(led2), int'(e[2:0]));
  end

  task automatic wr(input int ch, input int m, input int p, input int d,
                    input bit keep = 1'b0);
    int k;
    k = 0;
    cfg_valid = 1'b1;
    cfg_ch    = ch[1:0];
    cfg_mode  = m[1:0];
    cfg_per   = p[PW-1:0];
    cfg_duty  = d[PW-1:0];
    while (!ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("wr_ready_wait", int'(k < 200), 1);
    @(negedge clk);
    if (!keep) cfg_valid = 1'b0;
  endtask

  task automatic wait_led(input int idx, input bit lvl);
    int k;
    k = 0;
    while (led[idx] != lvl && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("wait_led", int'(k < 400), 1);
  endtask

  task automatic run_len(input int idx, input bit lvl, output int n);
    n = 0;
    while (led[idx] == lvl && n < 400) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic tick_gap(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 50);
  endtask

  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_led", int'(led), 0);
    chk("rst_ready", int'(ready), 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n, k;
    repeat (3) @(negedge clk);
    chk("reset_led", int'(led), 0);
    chk("reset_ready", int'(ready), 1);
    chk("reset_tick", int'(tick), 0);
    rst_n = 1'b1;
    tick_gap(n);
    chk("first_tick", n, 10);
    tick_gap(n);
    chk("tick_period", n, 10);

    wr(0, 2, 4, 1);
    wait_led(0, 1'b1);
    run_len(0, 1'b1, n);
    chk("blink_high", n, 10);
    run_len(0, 1'b0, n);
    chk("blink_low", n, 30);
    chk("blink_others", int'(led[3:1]), 0);
    run_len(0, 1'b1, n);
    chk("blink_high2", n, 10);

    wait_led(0, 1'b1);
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_mode = 2'd1;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("pend_ready", int'(ready), 0);
    mid_reset();
    tick_gap(n);
    chk("rst_first_tick", n, 10);

    wr(1, 1, 0, 0, 1'b1);
    wr(2, 2, 3, 1);
    chk("hs_led1", int'(led[1]), 1);

    wr(3, 3, 0, 3);
    wait_led(3, 1'b1);
    run_len(3, 1'b1, n);
    chk("oneshot_high", n, 30);
    k = 0;
    repeat (100) begin
      @(negedge clk);
      if (led[3]) k++;
    end
    chk("oneshot_stays_off", k, 0);
    wr(3, 2, 4, 2);
    wait_led(3, 1'b1);

    wr(0, 2, 0, 1);
    wr(1, 2, 3, 5);
    wr(2, 2, 5, 0);
    repeat (12) @(negedge clk);
    chk("bound_a", int'(led[2:0]), 3);
    repeat (17) @(negedge clk);
    chk("bound_b", int'(led[2:0]), 3);
    wr(3, 1, 0, 0);
    repeat (12) @(negedge clk);
    chk("oor_main_ch3", int'(led[3]), 1);
    chk("oor_small", int'(led2), 3);

    k = 0;
    while (!tick && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("find_tick", int'(tick), 1);
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_mode = 2'd0;
    cfg_per = '0; cfg_duty = '0;
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("tick_acc_ready", int'(ready), 0);
    k = 1;
    while (led[1] && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("tick_acc_apply", k, 11);

    for (int it = 0; it < 250; it++) begin
      repeat ($urandom_range(0, 15)) @(negedge clk);
      if ($urandom_range(0, 39) == 0) mid_reset();
      wr($urandom_range(0, 3), $urandom_range(0, 3),
         $urandom_range(0, 6), $urandom_range(0, 7),
         bit'($urandom_range(0, 1)));
    end
    cfg_valid = 1'b0;
    repeat (40) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
